mem_access_stage: RTL and testbench

Pipeline MEM stage of the 8-bit MIPS core, directly upstream of `data_memory`. It accepts one request per handshake from execute: ALU pass-through, load or store. It drives `data_memory`'s synchronous port, never asserting read and write together, and captures load data one cycle after issue. Results go to writeback through a one-entry valid/ready output register.

---
 rtl/mips8_pkg.sv | 26 ++
 rtl/mem_access_stage_wb_slot.sv | 43 ++++
 rtl/mem_access_stage.sv | 113 +++++++++++
 tb/tb_mem_access_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit MIPS core: widths, MEM-stage opcodes and
// MEM-stage FSM state encodings.
package mips8_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  typedef logic [1:0] ex_op_t;

  localparam ex_op_t OP_PASS    = 2'b00;
  localparam ex_op_t OP_LOAD    = 2'b01;
  localparam ex_op_t OP_STORE   = 2'b10;
  localparam ex_op_t OP_ILLEGAL = 2'b11;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_READ = 1'b1;

  // Only PASS and LOAD produce a value that writeback commits to the register file.
  function automatic logic op_writes_reg(input ex_op_t op);
    return (op == OP_PASS) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/mem_access_stage_wb_slot.sv
// One-entry valid/ready output register between the MEM stage and writeback.
// A load takes priority over a drain, so a same-edge consume-and-refill keeps valid high.
module wb_slot
  import mips8_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_W_P  = REG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_W_P-1:0] load_data,
  input  logic [REG_W_P-1:0]  load_rd,
  input  logic                load_reg_write,
  input  logic                ready,
  output logic                slot_free,
  output logic                valid,
  output logic [DATA_W_P-1:0] data,
  output logic [REG_W_P-1:0]  rd,
  output logic                reg_write
);

  assign slot_free = !valid || ready;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= 1'b0;
      data      <= '0;
      rd        <= '0;
      reg_write <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      data      <= load_data;
      rd        <= load_rd;
      reg_write <= load_reg_write;
    end else if (ready) begin
      valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to data_memory, captures load data one
// cycle after issue and hands results to writeback through a one-entry slot.
module mem_access_stage
  import mips8_pkg::*;
#(
  parameter int ADDR_W = mips8_pkg::ADDR_W,
  parameter int DATA_W = mips8_pkg::DATA_W,
  parameter int REG_W  = mips8_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_rd,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_reg_write,
  output logic              err_illegal
);

  state_t            state;
  logic [REG_W-1:0]  load_rd_q;
  logic              slot_free;
  logic              accept;
  logic              slot_load;
  logic [DATA_W-1:0] slot_data;
  logic [REG_W-1:0]  slot_rd;
  logic              slot_reg_write;

  // Gating with reset keeps a store that coincides with reset assertion out of memory.
  assign ex_ready = (state == ST_IDLE) && slot_free && !reset;
  assign accept   = ex_valid && ex_ready;

  assign mem_address      = ex_addr;
  assign mem_data_in      = ex_wdata;
  assign mem_read_enable  = accept && (ex_op == OP_LOAD);
  assign mem_write_enable = accept && (ex_op == OP_STORE);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    slot_load      = 1'b0;
    slot_data      = '0;
    slot_rd        = ex_rd;
    slot_reg_write = 1'b0;
    if (state == ST_READ) begin
      slot_load      = 1'b1;
      slot_data      = mem_data_out;
      slot_rd        = load_rd_q;
      slot_reg_write = 1'b1;
    end else if (accept && (ex_op != OP_LOAD)) begin
      slot_load      = 1'b1;
      slot_data      = (ex_op == OP_PASS) ? ex_wdata : '0;
      slot_reg_write = op_writes_reg(ex_op);
    end
  end

  // READ always returns to IDLE: the slot was free at accept and nothing filled it since.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      load_rd_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (ex_op == OP_LOAD)) begin
            state     <= ST_READ;
            load_rd_q <= ex_rd;
          end
        end
        ST_READ: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_illegal <= 1'b0;
    end else if (accept && (ex_op == OP_ILLEGAL)) begin
      err_illegal <= 1'b1;
    end
  end

  wb_slot #(
    .DATA_W_P (DATA_W),
    .REG_W_P  (REG_W)
  ) u_wb_slot (
    .clk            (clk),
    .reset          (reset),
    .load           (slot_load),
    .load_data      (slot_data),
    .load_rd        (slot_rd),
    .load_reg_write (slot_reg_write),
    .ready          (wb_ready),
    .slot_free      (slot_free),
    .valid          (wb_valid),
    .data           (wb_data),
    .rd             (wb_rd),
    .reg_write      (wb_reg_write)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small synchronous data_memory model.
module tb_mem_access_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid;
  logic       ex_ready;
  logic [1:0] ex_op;
  logic [7:0] ex_addr;
  logic [7:0] ex_wdata;
  logic [2:0] ex_rd;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write_enable;
  logic       mem_read_enable;
  logic [7:0] mem_data_out;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [2:0] wb_rd;
  logic       wb_reg_write;
  logic       err_illegal;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  // Synchronous data_memory: write and read both happen at the rising edge.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_data_in;
    if (mem_read_enable)  mem_data_out <= mem[mem_address];
  end

  mem_access_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_op            (ex_op),
    .ex_addr          (ex_addr),
    .ex_wdata         (ex_wdata),
    .ex_rd            (ex_rd),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_data_out     (mem_data_out),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_data          (wb_data),
    .wb_rd            (wb_rd),
    .wb_reg_write     (wb_reg_write),
    .err_illegal      (err_illegal)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [2:0] rd);
    ex_valid = v;
    ex_op    = op;
    ex_addr  = addr;
    ex_wdata = wdata;
    ex_rd    = rd;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_wb(input string name, input logic v, input logic [7:0] d,
                        input logic [2:0] r, input logic rw);
    checks++;
    if ({wb_valid, wb_data, wb_rd, wb_reg_write} !== {v, d, r, rw}) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h rd=%0d rw=%b expected valid=%b data=%h rd=%0d rw=%b",
               name, wb_valid, wb_data, wb_rd, wb_reg_write, v, d, r, rw);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    wb_ready = 1'b1;
    reset    = 1'b1;
    #2;
    chk_wb("reset_wb", 1'b0, 8'h00, 3'd0, 1'b0);
    chk1("reset_err", err_illegal, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b1, 2'b00, 8'h00, 8'hA5, 3'd7);
    tick();
    chk_wb("pre_reset_entry", 1'b1, 8'hA5, 3'd7, 1'b1);
    // Mid-cycle reset with a store offered: everything must drop at once.
    drive(1'b1, 2'b10, 8'h20, 8'h99, 3'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_wb("midcycle_reset_wb", 1'b0, 8'h00, 3'd0, 1'b0);
    chk1("midcycle_reset_ex_ready", ex_ready, 1'b0);
    chk1("midcycle_reset_wen", mem_write_enable, 1'b0);
    chk1("midcycle_reset_ren", mem_read_enable, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    reset = 1'b0;
    #1;
    chk1("after_reset_ex_ready", ex_ready, 1'b1);
    tick();
  endtask

  task automatic test_pass();
    drive(1'b1, 2'b00, 8'h33, 8'h5A, 3'd3);
    #1;
    chk1("pass_ex_ready", ex_ready, 1'b1);
    chk1("pass_wen", mem_write_enable, 1'b0);
    chk1("pass_ren", mem_read_enable, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    chk_wb("pass_wb", 1'b1, 8'h5A, 3'd3, 1'b1);
    tick();
    chk_wb("pass_drained", 1'b0, 8'h5A, 3'd3, 1'b1);
  endtask

  task automatic test_store_load();
    drive(1'b1, 2'b10, 8'h10, 8'hC3, 3'd1);
    #1;
    chk1("store_wen", mem_write_enable, 1'b1);
    chk1("store_ren", mem_read_enable, 1'b0);
    checks++;
    if ({mem_address, mem_data_in} !== {8'h10, 8'hC3}) begin
      errors++;
      $display("FAIL store_bus: got addr=%h data=%h expected addr=10 data=c3", mem_address, mem_data_in);
    end
    tick();
    chk_wb("store_wb", 1'b1, 8'h00, 3'd1, 1'b0);
    drive(1'b1, 2'b01, 8'h10, 8'h00, 3'd5);
    #1;
    chk1("load_ren", mem_read_enable, 1'b1);
    chk1("load_wen", mem_write_enable, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    chk1("load_read_ex_ready", ex_ready, 1'b0);
    chk1("load_read_wb_valid", wb_valid, 1'b0);
    tick();
    chk_wb("load_wb", 1'b1, 8'hC3, 3'd5, 1'b1);
    chk1("load_done_ex_ready", ex_ready, 1'b1);
    // Back-to-back: a store-gated-by-reset earlier must have left 0x20 untouched.
    drive(1'b1, 2'b01, 8'h20, 8'h00, 3'd6);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    tick();
    chk_wb("gated_store_not_written", 1'b1, 8'h00, 3'd6, 1'b1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 8'h00, 8'h77, 3'd6);
    tick();
    chk_wb("b2b_first", 1'b1, 8'h77, 3'd6, 1'b1);
    drive(1'b1, 2'b00, 8'h00, 8'h88, 3'd2);
    #1;
    chk1("b2b_ex_ready", ex_ready, 1'b1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    chk_wb("b2b_second", 1'b1, 8'h88, 3'd2, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    drive(1'b1, 2'b00, 8'h00, 8'h11, 3'd1);
    tick();
    chk_wb("bp_first", 1'b1, 8'h11, 3'd1, 1'b1);
    drive(1'b1, 2'b00, 8'h00, 8'h22, 3'd2);
    #1;
    chk1("bp_ex_ready_low", ex_ready, 1'b0);
    tick();
    chk_wb("bp_hold", 1'b1, 8'h11, 3'd1, 1'b1);
    wb_ready = 1'b1;
    #1;
    chk1("bp_ex_ready_high", ex_ready, 1'b1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    chk_wb("bp_refill", 1'b1, 8'h22, 3'd2, 1'b1);
    tick();
    chk1("bp_drained", wb_valid, 1'b0);
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b11, 8'h40, 8'hEE, 3'd2);
    #1;
    chk1("illegal_wen", mem_write_enable, 1'b0);
    chk1("illegal_ren", mem_read_enable, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    chk_wb("illegal_wb", 1'b1, 8'h00, 3'd2, 1'b0);
    chk1("illegal_err", err_illegal, 1'b1);
    tick();
    tick();
    chk1("illegal_err_sticky", err_illegal, 1'b1);
  endtask

  task automatic test_reset_in_read();
    drive(1'b1, 2'b01, 8'h10, 8'h00, 3'd4);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
    chk1("rr_in_read_ex_ready", ex_ready, 1'b0);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk1("rr_ex_ready_after", ex_ready, 1'b1);
    chk1("rr_err_cleared", err_illegal, 1'b0);
    tick();
    chk1("rr_no_wb", wb_valid, 1'b0);
    tick();
    chk1("rr_no_wb_later", wb_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_data_out = 8'h00;
    test_reset();
    test_pass();
    test_store_load();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_in_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
